// File: rtl/acc_core_multi_pkg.sv
// Shared definitions for the multi-lane accumulator: FSM state codes and the
// per-lane add-with-overflow helper.
package acc_core_multi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Working width of sat_add; must be at least DWIDTH+1 of any user.
    localparam int unsigned SA_W = 32;
    typedef logic [SA_W-1:0] sa_word_t;

    // acc/opnd arrive already extended (sign or zero) past bit dw; returns {ovf, sum}
    // with the valid result in sum[dw-1:0].
    function automatic logic [SA_W:0] sat_add(input sa_word_t acc, input sa_word_t opnd,
                                              input logic sgn, input logic sat_en,
                                              input int unsigned dw);
        sa_word_t sum;
        sa_word_t maxv;
        sa_word_t minv;
        logic     ovf;
        sum  = acc + opnd;
        ovf  = sgn ? (sum[dw] != sum[dw-1]) : sum[dw];
        maxv = sgn ? ((SA_W'(1) << (dw - 1)) - SA_W'(1)) : ((SA_W'(1) << dw) - SA_W'(1));
        minv = sgn ? (SA_W'(1) << (dw - 1)) : '0;
        // sum[dw] carries the true sign of the signed result, so it picks the clamp rail
        if (ovf && sat_en) begin
            sum = (sgn && sum[dw]) ? minv : maxv;
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/acc_core_multi_if.sv
// Job/operand/result bundle of acc_core_multi; slave side is the accumulator.
interface acc_core_multi_if #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned DWIDTH        = 16,
    parameter int unsigned CNT_W         = 8
);
    logic                            run_i;
    logic [CNT_W-1:0]                len_i;
    logic                            signed_i;
    logic                            sat_en_i;
    logic                            valid_i;
    logic [NUM_CH*IN_DATA_WIDTH-1:0] number_i;
    logic                            ready_o;
    logic                            busy_o;
    logic                            valid_o;
    logic [NUM_CH*DWIDTH-1:0]        result_o;
    logic [NUM_CH-1:0]               ovf_o;

    modport slave (
        input  run_i, len_i, signed_i, sat_en_i, valid_i, number_i,
        output ready_o, busy_o, valid_o, result_o, ovf_o
    );

    modport master (
        output run_i, len_i, signed_i, sat_en_i, valid_i, number_i,
        input  ready_o, busy_o, valid_o, result_o, ovf_o
    );
endinterface

// File: rtl/acc_core_multi_lane.sv
// One accumulator lane: DWIDTH accumulator plus sticky overflow flag,
// signed/unsigned with optional saturation.
module acc_lane
    import acc_core_multi_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned DWIDTH        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     add_en,
    input  logic [IN_DATA_WIDTH-1:0] operand,
    input  logic                     sgn,
    input  logic                     sat_en,
    output logic [DWIDTH-1:0]        acc,
    output logic                     ovf
);

    sa_word_t      acc_w;
    sa_word_t      op_w;
    logic [SA_W:0] res;
    logic          unused_hi;

    always_comb begin
        acc_w = SA_W'(acc);
        op_w  = SA_W'(operand);
        if (sgn) begin
            acc_w = SA_W'($signed(acc));
            op_w  = SA_W'($signed(operand));
        end
    end

    assign res       = sat_add(acc_w, op_w, sgn, sat_en, DWIDTH);
    assign unused_hi = ^res[SA_W-1:DWIDTH];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            acc <= res[DWIDTH-1:0];
            ovf <= ovf | res[SA_W];
        end
    end

endmodule

// File: rtl/acc_core_multi.sv
// Multi-channel length-counted accumulator: run_i arms a job of len_i beats,
// each accepted beat adds one operand per lane, valid_o pulses when done.
module acc_core_multi
    import acc_core_multi_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned DWIDTH        = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    acc_core_multi_if.slave  bus
);

    logic [1:0]               state;
    logic [1:0]               state_nx;
    logic [CNT_W-1:0]         cnt;
    logic                     sgn_q;
    logic                     sat_q;
    logic                     ready;
    logic                     accept;
    logic                     last_beat;
    logic [DWIDTH-1:0]        lane_acc [NUM_CH];
    logic [NUM_CH-1:0]        lane_ovf;
    logic [NUM_CH*DWIDTH-1:0] result_p;

    assign ready     = (state == ST_ACC);
    // run_i wins over a beat presented in the same cycle
    assign accept    = bus.valid_i & ready & ~bus.run_i;
    assign last_beat = accept & (cnt == CNT_W'(1));

    always_comb begin
        state_nx = state;
        if (bus.run_i) begin
            state_nx = (bus.len_i == '0) ? ST_DONE : ST_ACC;
        end else begin
            case (state)
                ST_ACC:  if (last_beat) state_nx = ST_DONE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sgn_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.run_i) begin
                cnt   <= bus.len_i;
                sgn_q <= bus.signed_i;
                sat_q <= bus.sat_en_i;
            end else if (accept) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        acc_lane #(
            .IN_DATA_WIDTH(IN_DATA_WIDTH),
            .DWIDTH       (DWIDTH)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (bus.run_i),
            .add_en (accept),
            .operand(bus.number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .sgn    (sgn_q),
            .sat_en (sat_q),
            .acc    (lane_acc[k]),
            .ovf    (lane_ovf[k])
        );
    end

    always_comb begin
        result_p = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            result_p[k*DWIDTH +: DWIDTH] = lane_acc[k];
        end
    end

    assign bus.ready_o  = ready;
    assign bus.busy_o   = (state != ST_IDLE);
    assign bus.valid_o  = (state == ST_DONE);
    assign bus.result_o = result_p;
    assign bus.ovf_o    = lane_ovf;

endmodule

// File: tb/tb_acc_core_multi.sv
// Scoreboard bench for acc_core_multi: a 16-bit and a 12-bit instance see the
// same stimulus; expected sums come from an integer reference model.
module tb_acc_core_multi;

    typedef struct {
        logic [63:0] r16;
        logic [3:0]  o16;
        logic [47:0] r12;
        logic [3:0]  o12;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    acc_core_multi_if #(.NUM_CH(4), .IN_DATA_WIDTH(8), .DWIDTH(16), .CNT_W(8)) b16 ();
    acc_core_multi_if #(.NUM_CH(4), .IN_DATA_WIDTH(8), .DWIDTH(12), .CNT_W(8)) b12 ();

    acc_core_multi #(.NUM_CH(4), .IN_DATA_WIDTH(8), .DWIDTH(16), .CNT_W(8)) dut16 (
        .clk(clk), .reset(reset), .bus(b16));
    acc_core_multi #(.NUM_CH(4), .IN_DATA_WIDTH(8), .DWIDTH(12), .CNT_W(8)) dut12 (
        .clk(clk), .reset(reset), .bus(b12));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic run, input logic [7:0] len, input logic sg,
                         input logic sat, input logic vld, input logic [31:0] num);
        b16.run_i = run; b16.len_i = len; b16.signed_i = sg; b16.sat_en_i = sat;
        b16.valid_i = vld; b16.number_i = num;
        b12.run_i = run; b12.len_i = len; b12.signed_i = sg; b12.sat_en_i = sat;
        b12.valid_i = vld; b12.number_i = num;
    endtask

    task automatic drive_idle();
        drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, $urandom());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Integer model: true sum per lane, range check, then clamp or wrap.
    function automatic void model(input logic [31:0] ops[$], input bit sg, input bit sat,
                                  input int dw, output logic [63:0] res, output logic [3:0] ovf);
        longint      mx, mn, acc, v;
        logic [63:0] mask;
        logic [7:0]  b;
        res  = '0;
        ovf  = '0;
        mask = (64'd1 << dw) - 64'd1;
        mx   = sg ? (longint'(1) <<< (dw - 1)) - 1 : (longint'(1) <<< dw) - 1;
        mn   = sg ? -(longint'(1) <<< (dw - 1)) : 0;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            foreach (ops[i]) begin
                b   = ops[i][k*8 +: 8];
                v   = sg ? longint'($signed(b)) : longint'(b);
                acc = acc + v;
                if (acc > mx || acc < mn) begin
                    ovf[k] = 1'b1;
                    if (sat) begin
                        acc = (acc > mx) ? mx : mn;
                    end else begin
                        acc = longint'(64'(acc) & mask);
                        if (acc > mx) acc = acc - 2 * (mx + 1);
                    end
                end
            end
            res = res | ((64'(acc) & mask) << (k * dw));
        end
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ready16"}, 64'(b16.ready_o), 0);
        chk({tag, "_busy16"}, 64'(b16.busy_o), 0);
        chk({tag, "_valid16"}, 64'(b16.valid_o), 0);
        chk({tag, "_result16"}, 64'(b16.result_o), 0);
        chk({tag, "_ovf16"}, 64'(b16.ovf_o), 0);
        chk({tag, "_busy12"}, 64'(b12.busy_o), 0);
        chk({tag, "_result12"}, 64'(b12.result_o), 0);
        chk({tag, "_ovf12"}, 64'(b12.ovf_o), 0);
    endtask

    // Starts a job that is never completed (aborted or reset afterwards).
    task automatic partial(input int len, input int nbeats);
        drive(1'b1, 8'(len), 1'($urandom), 1'($urandom), 1'b0, $urandom());
        tick();
        for (int i = 0; i < nbeats; i++) begin
            drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, $urandom());
            tick();
        end
        drive_idle();
    endtask

    task automatic run_job(input int len, input bit sg, input bit sat, input bit fixed,
                           input logic [31:0] word, input int maxgap, input bit stay_done);
        logic [31:0] ops[$];
        logic [63:0] r;
        logic [3:0]  o;
        exp_t        e;
        for (int i = 0; i < len; i++) ops.push_back(fixed ? word : $urandom());
        model(ops, sg, sat, 16, r, o);
        e.r16 = r; e.o16 = o;
        model(ops, sg, sat, 12, r, o);
        e.r12 = r[47:0]; e.o12 = o;
        sbq.push_back(e);
        // a beat offered alongside run_i must be dropped
        drive(1'b1, 8'(len), sg, sat, 1'($urandom), $urandom());
        tick();
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                drive_idle();
                tick();
            end
            if (i == 0) chk("ready_in_acc", 64'(b16.ready_o), 1);
            drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, ops[i]);
            tick();
        end
        drive_idle();
        chk("latency16", 64'(b16.valid_o), 1);
        chk("latency12", 64'(b12.valid_o), 1);
        chk("ready_in_done", 64'(b16.ready_o), 0);
        if (!stay_done) tick();
    endtask

    always @(negedge clk) begin
        if (b16.valid_o || b12.valid_o) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got valid16=%b valid12=%b expected none at %0t",
                         b16.valid_o, b12.valid_o, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("valid_pair", 64'(b12.valid_o), 64'(b16.valid_o));
                chk("result16", 64'(b16.result_o), e.r16);
                chk("ovf16", 64'(b16.ovf_o), 64'(e.o16));
                chk("result12", 64'(b12.result_o), 64'(e.r12));
                chk("ovf12", 64'(b12.ovf_o), 64'(e.o12));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // lane k = k+1, contiguous then with gaps
        run_job(4, 0, 0, 1, 32'h04030201, 0, 0);
        run_job(4, 0, 0, 1, 32'h04030201, 3, 0);

        // reset after 3 of 5 beats
        partial(5, 3);
        reset = 1'b1;
        tick();
        chk_zero("midjob_reset");
        reset = 1'b0;
        tick();

        // long jobs: 255 and -128 per beat, each mode
        w = {8'($urandom), 8'($urandom), 8'h80, 8'hFF};
        run_job(255, 0, 1, 1, w, 0, 0);
        run_job(255, 1, 1, 1, w, 0, 0);
        run_job(255, 1, 0, 1, w, 0, 0);

        // abort after 2 of 6 beats
        partial(6, 2);
        run_job(3, 0, 0, 0, 32'd0, 1, 0);

        // zero-length job, restarted during its done cycle
        run_job(0, 0, 0, 0, 32'd0, 0, 1);
        run_job(3, 1, 1, 0, 32'd0, 2, 0);

        repeat (25) run_job($urandom_range(1, 20), 1'($urandom), 1'($urandom), 0, 32'd0, 2,
                            1'($urandom));
        repeat (4) run_job($urandom_range(100, 255), 1'($urandom), 1'($urandom), 0, 32'd0, 1, 0);

        repeat (3) tick();
        chk("scoreboard_empty", 64'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
